// File: rtl/window3x3_gen.sv
// 3x3 sliding-window generator: two line buffers feed a 3x3 register window
// that shifts one column per accepted pixel. Outputs are registered (latency 1).
module window3x3_gen #(
    parameter int DATA_W = 10,
    parameter int LINE_W = 640
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iSOF,
    input  logic                  iDVAL,
    input  logic [DATA_W-1:0]     iPixel,
    output logic [9*DATA_W-1:0]   oGrid,
    output logic                  oDVAL,
    output logic [10:0]           oX,
    output logic [10:0]           oY
);
    localparam int AW = $clog2(LINE_W);

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

    state_t            state_q, state_d;
    logic [10:0]       col_q, col_d, row_q, row_d;
    logic [10:0]       cur_col, cur_row;
    logic [AW-1:0]     addr;
    logic              accept, win_vld;
    logic [DATA_W-1:0] lb1 [LINE_W];
    logic [DATA_W-1:0] lb2 [LINE_W];
    logic [DATA_W-1:0] lb1_rd, lb2_rd;
    logic [DATA_W-1:0] win_q [9];
    logic [DATA_W-1:0] win_d [9];

    // A pixel arriving with iSOF is pixel (0,0) of the new frame.
    always_comb begin
        cur_col = iSOF ? 11'd0 : col_q;
        cur_row = iSOF ? 11'd0 : row_q;
        accept  = iDVAL && (iSOF || state_q != IDLE);
        win_vld = accept && (cur_row >= 11'd2) && (cur_col >= 11'd2);
        addr    = cur_col[AW-1:0];
        lb1_rd  = lb1[addr];
        lb2_rd  = lb2[addr];
    end

    always_comb begin
        col_d = cur_col;
        row_d = cur_row;
        if (accept) begin
            if (cur_col == 11'(LINE_W - 1)) begin
                col_d = 11'd0;
                if (cur_row != 11'd2047) row_d = cur_row + 11'd1;
            end else begin
                col_d = cur_col + 11'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (iSOF)                                   state_d = FILL;
        else if (state_q == FILL && row_q >= 11'd2) state_d = RUN;
    end

    // Each window row takes its newest sample from the input or a line buffer.
    always_comb begin
        for (int dy = 0; dy < 3; dy++) begin
            win_d[3*dy+1] = win_q[3*dy];
            win_d[3*dy+2] = win_q[3*dy+1];
        end
        win_d[0] = iPixel;
        win_d[3] = lb1_rd;
        win_d[6] = lb2_rd;
    end

    always_comb begin
        oGrid = '0;
        for (int k = 0; k < 9; k++) oGrid[k*DATA_W +: DATA_W] = win_q[k];
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            oDVAL   <= 1'b0;
            oX      <= '0;
            oY      <= '0;
            for (int k = 0; k < 9; k++) win_q[k] <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            oDVAL   <= win_vld;
            if (accept) begin
                for (int k = 0; k < 9; k++) win_q[k] <= win_d[k];
            end
            if (win_vld) begin
                oX <= cur_col - 11'd1;
                oY <= cur_row - 11'd1;
            end
        end
    end

    // Line buffers are not reset; rows 0 and 1 of each frame overwrite them
    // before any window can be flagged valid.
    always_ff @(posedge iCLK) begin
        if (accept && !iRST) begin
            lb1[addr] <= iPixel;
            lb2[addr] <= lb1_rd;
        end
    end
endmodule

// File: tb/tb_window3x3_gen.sv
// Directed bench for window3x3_gen with LINE_W=8 ramp frames.
module tb_window3x3_gen;
    localparam int DW = 10;
    localparam int LW = 8;

    logic            iCLK = 1'b0;
    logic            iRST, iSOF, iDVAL;
    logic [DW-1:0]   iPixel;
    logic [9*DW-1:0] oGrid;
    logic            oDVAL;
    logic [10:0]     oX, oY;

    typedef struct {
        logic [9*DW-1:0] g;
        logic [10:0]     x;
        logic [10:0]     y;
    } win_t;

    win_t q[$];
    int   total = 0;
    int   bad   = 0;
    logic dv_s  = 1'b0;

    window3x3_gen #(.DATA_W(DW), .LINE_W(LW)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSOF(iSOF), .iDVAL(iDVAL), .iPixel(iPixel),
        .oGrid(oGrid), .oDVAL(oDVAL), .oX(oX), .oY(oY)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge iCLK) dv_s <= iDVAL;

    // Every window must follow a cycle in which iDVAL was high.
    always @(negedge iCLK) begin
        if (oDVAL) begin
            chk("lat", {95'd0, dv_s}, 96'd1);
            q.push_back('{g: oGrid, x: oX, y: oY});
        end
    end

    task automatic px(input logic sof, input logic dv, input int val);
        @(negedge iCLK);
        iSOF   = sof;
        iDVAL  = dv;
        iPixel = DW'(val);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(1'b0, 1'b0, 0);
    endtask

    // sof_sep: iSOF in its own cycle before pixel 0; otherwise with pixel 0.
    task automatic frame(input int h, input bit gap, input bit sof_sep,
                         input int base, input int npix);
        int n;
        n = 0;
        if (sof_sep) px(1'b1, 1'b0, 0);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < LW; c++) begin
                if (n == npix) return;
                px(!sof_sep && n == 0, 1'b1, base + LW*r + c);
                n++;
                if (gap) idle(2);
            end
        end
    endtask

    function automatic logic [9*DW-1:0] exp_grid(input int r, input int c, input int base);
        logic [9*DW-1:0] g;
        g = '0;
        for (int k = 0; k < 9; k++)
            g[k*DW +: DW] = DW'(base + LW*(r - k/3) + (c - k%3));
        return g;
    endfunction

    task automatic check_frame(input string tag, input int base);
        int n, r, c;
        chk({tag, "_cnt"}, 96'(q.size()), 96'd18);
        n = (q.size() < 18) ? q.size() : 18;
        for (int i = 0; i < n; i++) begin
            r = 2 + i / 6;
            c = 2 + i % 6;
            chk({tag, "_grid"}, 96'(q[i].g), 96'(exp_grid(r, c, base)));
            chk({tag, "_x"}, 96'(q[i].x), 96'(c - 1));
            chk({tag, "_y"}, 96'(q[i].y), 96'(r - 1));
        end
        q.delete();
    endtask

    initial begin
        logic [9*DW-1:0] g0;
        iRST = 1'b1; iSOF = 1'b0; iDVAL = 1'b0; iPixel = '0;
        repeat (3) @(negedge iCLK);
        chk("rst_dval", 96'(oDVAL), 96'd0);
        chk("rst_grid", 96'(oGrid), 96'd0);
        chk("rst_x",    96'(oX),    96'd0);
        chk("rst_y",    96'(oY),    96'd0);
        iRST = 1'b0;

        // Pixels before any iSOF are ignored.
        for (int i = 0; i < 20; i++) px(1'b0, 1'b1, i + 3);
        idle(2);
        chk("presof_cnt", 96'(q.size()), 96'd0);
        q.delete();

        // Separate iSOF, continuous ramp: first window (2,2).
        frame(5, 1'b0, 1'b1, 0, 40);
        idle(3);
        if (q.size() > 0) begin
            g0 = q[0].g;
            chk("a_tap0", 96'(g0[0 +: DW]),    96'd18);
            chk("a_tap8", 96'(g0[8*DW +: DW]), 96'd0);
            chk("a_x0",   96'(q[0].x),         96'd1);
            chk("a_y0",   96'(q[0].y),         96'd1);
        end
        check_frame("a", 0);

        // Same frame with iDVAL pattern 1,0,0.
        frame(5, 1'b1, 1'b1, 0, 40);
        idle(3);
        check_frame("gap", 0);

        // iSOF together with the first pixel, offset ramp.
        frame(5, 1'b0, 1'b0, 200, 40);
        idle(3);
        if (q.size() > 0) begin
            g0 = q[0].g;
            chk("s_tap8", 96'(g0[8*DW +: DW]), 96'd200);
            chk("s_x0",   96'(q[0].x),         96'd1);
            chk("s_y0",   96'(q[0].y),         96'd1);
        end
        check_frame("s", 200);

        // Abort at row 3 col 4, then a full new frame.
        frame(5, 1'b0, 1'b0, 0, 28);
        idle(2);
        q.delete();
        frame(5, 1'b0, 1'b0, 100, 40);
        idle(3);
        check_frame("abort", 100);

        // Reset mid-RUN with iDVAL high.
        frame(5, 1'b0, 1'b0, 0, 20);
        @(negedge iCLK);
        iRST = 1'b1; iSOF = 1'b0; iDVAL = 1'b1; iPixel = DW'(55);
        @(negedge iCLK);
        chk("mrst_dval", 96'(oDVAL), 96'd0);
        chk("mrst_grid", 96'(oGrid), 96'd0);
        chk("mrst_x",    96'(oX),    96'd0);
        iRST = 1'b0;
        q.delete();
        for (int i = 0; i < 40; i++) px(1'b0, 1'b1, i + 7);
        idle(2);
        chk("mrst_ign", 96'(q.size()), 96'd0);
        chk("mrst_hold", 96'(oGrid), 96'd0);
        q.delete();
        frame(5, 1'b0, 1'b1, 300, 40);
        idle(3);
        check_frame("recov", 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
